// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event pulses into level pulses lasting PULSE_CNT_MAX
// ticks of a shared free-running prescaler, one independent lane per bit.
module pulse_stretcher #(
  parameter int WIDTH          = 1,
  parameter int SAMPLE_CNT_MAX = 62500,
  parameter int PULSE_CNT_MAX  = 200,
  parameter int RETRIGGER      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pulse_in,
  input  logic [WIDTH-1:0] clear_dropped,
  output logic [WIDTH-1:0] stretched_out,
  output logic [WIDTH-1:0] dropped
);

  localparam int PW = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
  localparam int RW = (PULSE_CNT_MAX > 0) ? $clog2(PULSE_CNT_MAX + 1) : 1;
  localparam logic [PW-1:0] TICK_VAL = PW'(SAMPLE_CNT_MAX - 1);
  localparam logic [RW-1:0] RELOAD   = RW'(PULSE_CNT_MAX);
  localparam logic [RW-1:0] LAST     = RW'(1);
  localparam bit            RETRIG   = (RETRIGGER != 0);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [PW-1:0] presc;
  logic          tick;

  assign tick = (presc == TICK_VAL);

  // Shared prescaler: never restarted by pulses, so hold time depends on tick phase.
  always_ff @(posedge clk) begin
    if (rst || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    state_t        state;
    logic [RW-1:0] rem;
    logic          drop_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        state  <= IDLE;
        rem    <= '0;
        drop_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // A tick coinciding with the trigger is deliberately not counted.
            if (pulse_in[i]) begin
              state <= ACTIVE;
              rem   <= RELOAD;
            end
          end
          ACTIVE: begin
            if (pulse_in[i] && RETRIG) begin
              rem <= RELOAD;
            end else if (tick) begin
              if (rem == LAST) begin
                state <= IDLE;
                rem   <= '0;
              end else begin
                rem <= rem - 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
            rem   <= '0;
          end
        endcase

        // Set takes priority over clear when both land in the same cycle.
        if (!RETRIG && state == ACTIVE && pulse_in[i]) begin
          drop_q <= 1'b1;
        end else if (clear_dropped[i]) begin
          drop_q <= 1'b0;
        end
      end
    end

    assign stretched_out[i] = (state == ACTIVE);
    assign dropped[i]       = drop_q;
  end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Converts single-cycle event pulses, such as edge detector or UART strobes, into human-visible level pulses on LEDs and probe pins.
- Each lane's output is held high for a fixed number of slow "sample" ticks.
- The tick comes from one free-running wrapping counter shared by all lanes.
- Sits in io_circuits between pulse sources and board LEDs, with one instance per group of WIDTH lanes.

Parameters:
- WIDTH, 1: number of independent lanes.
- SAMPLE_CNT_MAX, 62500: prescaler period in clk cycles. Must be ≥ 2.
- PULSE_CNT_MAX, 200: output hold length, in sample ticks. Must be ≥ 1.
- RETRIGGER, 1:
  - 1 = a pulse during an active output reloads the hold count.
  - 0 = the pulse is ignored and flagged as dropped.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- pulse_in  input  WIDTH  per-lane event; each high cycle is one event.
- clear_dropped  input  WIDTH  per-lane clear for the dropped flag.
- stretched_out  output  WIDTH  per-lane stretched level.
- dropped  output  WIDTH  per-lane sticky flag: an event arrived while active with RETRIGGER=0.

Behaviour:
- Reset (synchronous, active-high):
  - Prescaler = 0.
  - All lanes IDLE, remaining count = 0.
  - stretched_out = 0, dropped = 0.
  - Reset mid-pulse drops the output in the cycle after rst is sampled.
- Prescaler:
  - Width clog2(SAMPLE_CNT_MAX).
  - tick = (prescaler == SAMPLE_CNT_MAX-1); prescaler wraps to 0 on tick, else increments.
  - Free-running and never restarted by pulses. Output duration therefore depends on tick phase.
- Per-lane registers: state (IDLE/ACTIVE) and rem, width clog2(PULSE_CNT_MAX+1). stretched_out[i] = (state == ACTIVE), registered.
- IDLE:
  - pulse_in[i]=1 → next cycle ACTIVE, rem = PULSE_CNT_MAX.
  - A tick in the trigger cycle is not counted.
- ACTIVE, no pulse:
  - On tick, rem decrements.
  - If rem == 1 on tick → next cycle IDLE, rem = 0.
- ACTIVE with pulse, RETRIGGER=1:
  - rem reloads to PULSE_CNT_MAX and the coincident tick is ignored.
  - This includes the final-tick cycle, so the output stays high with no gap.
- ACTIVE with pulse, RETRIGGER=0:
  - The pulse has no effect on state or rem; the tick is still counted.
  - dropped[i] sets next cycle.
  - A pulse on the final-tick cycle still ends the pulse, still sets dropped, and does not start a new pulse.
- Output timing:
  - High from the cycle after trigger.
  - Low from the cycle after the PULSE_CNT_MAX-th counted tick.
  - Duration is between (PULSE_CNT_MAX-1)·SAMPLE_CNT_MAX+1 and PULSE_CNT_MAX·SAMPLE_CNT_MAX cycles.
- dropped:
  - Sticky; cleared by clear_dropped[i] next cycle.
  - If a set condition and clear occur in the same cycle, set wins.
  - Always 0 when RETRIGGER=1.
- Lane independence: lanes never interact; simultaneous pulses on several lanes are all handled in the same cycle.
- Multi-cycle pulse_in:
  - Each high cycle is a separate event.
  - RETRIGGER=1: continuous reload, so the output stays high.
  - RETRIGGER=0: sets dropped from the second cycle on.

Test Plan:
Bench settings: SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, WIDTH=2. Cycle 0 is the first cycle after rst deasserts; ticks fall at cycles 3, 7, 11, 15, 19.
- Basic stretch: pulse_in[0] at cycle 1 → stretched_out[0] high cycles 2–11, low at 12 (10 cycles). dropped=0, lane 1 stays 0.
- Tick-coincident trigger: pulse at cycle 3 → high cycles 4–15, low at 16 (12 cycles; tick at 3 not counted).
- Retrigger (RETRIGGER=1): pulses at cycles 1 and 9 → high cycles 2–19, low at 20. Also pulse at final-tick cycle 11 → high continuously through cycle 23.
- No-retrigger (RETRIGGER=0): pulses at cycles 1 and 9 → low at 12, dropped[0] high from cycle 10. clear_dropped[0] at cycle 14 → dropped low at 15. clear and a new drop in the same cycle → dropped stays 1.
- Reset mid-pulse: pulse at cycle 1, rst high at cycle 5 → stretched_out=0 from cycle 6. After release, a new pulse restarts the full sequence with the prescaler back at phase 0.
- Independent lanes: pulse_in=2'b11 at cycle 1, pulse_in[1] again at cycle 9 (RETRIGGER=1) → lane 0 low at 12, lane 1 low at 20.
